// File: rtl/lvt_mp_ram.sv
// Multi-port RAM built from NUM_WR x NUM_RD single-writer/single-reader banks plus a
// live value table that steers each read port to the bank written last for its address.
module lvt_mp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter bit RDW_NEW    = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         ready,
    output logic                         wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LVT_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
    logic                           ready_q, ready_d;
    logic [NUM_RD-1:0]              rd_valid_q, rd_valid_d;
    logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                           wr_conflict_q, wr_conflict_d;

    logic [DATA_WIDTH-1:0]          bank_mem [NUM_WR][NUM_RD][DEPTH];
    logic [LVT_W-1:0]               lvt_mem [DEPTH];

    logic [NUM_WR-1:0]              port_we;
    logic [NUM_WR-1:0]              lvt_we;
    logic [ADDR_WIDTH-1:0]          port_addr [NUM_WR];
    logic [DATA_WIDTH-1:0]          port_data [NUM_WR];
    logic [LVT_W-1:0]               lvt_wval [NUM_WR];
    logic [ADDR_WIDTH-1:0]          rd_addr_s [NUM_RD];
    logic [DATA_WIDTH-1:0]          rd_word [NUM_RD];

    // The init sweep borrows every write port to clear one address per cycle; in RUN
    // only the lowest-index port among those sharing an address may claim the LVT entry.
    always_comb begin : write_ports
        port_we = '0;
        lvt_we  = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            port_addr[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
            port_data[w] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            lvt_wval[w]  = LVT_W'(w);
        end
        if (!reset && state_q == ST_INIT) begin
            for (int w = 0; w < NUM_WR; w++) begin
                port_we[w]   = 1'b1;
                port_addr[w] = cnt_q;
                port_data[w] = '0;
                lvt_wval[w]  = '0;
            end
            lvt_we[0] = 1'b1;
        end else if (!reset && ready_q) begin
            port_we = wr_en;
            for (int w = 0; w < NUM_WR; w++) begin
                lvt_we[w] = wr_en[w];
                for (int v = 0; v < w; v++) begin
                    if (wr_en[v] && port_addr[v] == port_addr[w]) begin
                        lvt_we[w] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin : read_ports
        for (int r = 0; r < NUM_RD; r++) begin
            rd_addr_s[r] = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word[r]   = bank_mem[lvt_mem[rd_addr_s[r]]][r][rd_addr_s[r]];
            if (RDW_NEW) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (lvt_we[w] && port_addr[w] == rd_addr_s[r]) begin
                        rd_word[r] = port_data[w];
                    end
                end
            end
        end
    end

    always_comb begin : control
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_d       = (state_q == ST_RUN);
        wr_conflict_d = 1'b0;
        rd_valid_d    = '0;
        rd_data_d     = rd_data_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
        // A port that wrote but lost its LVT claim collided with a lower-index port.
        if (ready_q) begin
            wr_conflict_d = |(port_we & ~lvt_we);
            rd_valid_d    = rd_en;
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r]) begin
                    rd_data_d[r*DATA_WIDTH +: DATA_WIDTH] = rd_word[r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    always_ff @(posedge clk) begin : memories
        for (int w = 0; w < NUM_WR; w++) begin
            if (port_we[w]) begin
                for (int r = 0; r < NUM_RD; r++) begin
                    bank_mem[w][r][port_addr[w]] <= port_data[w];
                end
            end
            if (lvt_we[w]) begin
                lvt_mem[port_addr[w]] <= lvt_wval[w];
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign ready       = ready_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_lvt_mp_ram.sv
// Bench for lvt_mp_ram: a 2W/2R old-data instance and a 4W/3R new-data instance share
// one stimulus stream and are checked against a flat-memory reference model.
module tb_lvt_mp_ram;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  s_wr_en = '0;
    logic [4:0]  s_wr_addr [4];
    logic [7:0]  s_wr_data [4];
    logic [2:0]  s_rd_en = '0;
    logic [4:0]  s_rd_addr [3];

    logic [15:0] a_rd_data;
    logic [1:0]  a_rd_valid;
    logic        a_ready, a_conf;
    logic [23:0] b_rd_data;
    logic [2:0]  b_rd_valid;
    logic        b_ready, b_conf;

    // Reference model: one plain word array per instance plus expected outputs.
    logic [7:0]  mem [2][32];
    logic [7:0]  exp_data [2][3];
    logic [2:0]  exp_valid [2];
    logic        exp_conf [2];
    int          edges   = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    lvt_mp_ram #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_WR(2), .NUM_RD(2), .RDW_NEW(1'b0)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (s_wr_en[1:0]),
        .wr_addr    ({s_wr_addr[1], s_wr_addr[0]}),
        .wr_data    ({s_wr_data[1], s_wr_data[0]}),
        .rd_en      (s_rd_en[1:0]),
        .rd_addr    ({s_rd_addr[1], s_rd_addr[0]}),
        .rd_data    (a_rd_data),
        .rd_valid   (a_rd_valid),
        .ready      (a_ready),
        .wr_conflict(a_conf)
    );

    lvt_mp_ram #(
        .DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_WR(4), .NUM_RD(3), .RDW_NEW(1'b1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (s_wr_en),
        .wr_addr    ({s_wr_addr[3], s_wr_addr[2], s_wr_addr[1], s_wr_addr[0]}),
        .wr_data    ({s_wr_data[3], s_wr_data[2], s_wr_data[1], s_wr_data[0]}),
        .rd_en      (s_rd_en),
        .rd_addr    ({s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]}),
        .rd_data    (b_rd_data),
        .rd_valid   (b_rd_valid),
        .ready      (b_ready),
        .wr_conflict(b_conf)
    );

    task automatic idle();
        s_wr_en = '0;
        s_rd_en = '0;
        for (int w = 0; w < 4; w++) begin
            s_wr_addr[w] = '0;
            s_wr_data[w] = '0;
        end
        for (int r = 0; r < 3; r++) s_rd_addr[r] = '0;
    endtask

    task automatic random_stim(input bit all_on, input int span);
        for (int w = 0; w < 4; w++) begin
            s_wr_en[w]   = all_on ? 1'b1 : 1'($urandom_range(0, 1));
            s_wr_addr[w] = 5'($urandom_range(0, span));
            s_wr_data[w] = 8'($urandom);
        end
        for (int r = 0; r < 3; r++) begin
            s_rd_en[r]   = all_on ? 1'b1 : 1'($urandom_range(0, 1));
            s_rd_addr[r] = 5'($urandom_range(0, span));
        end
    endtask

    // Lowest-index writer wins a shared address; reads see the word before or after the edge.
    task automatic model_edge(input int d, input int nw, input int nr, input bit rdw);
        logic [7:0] pre [32];
        logic       conf;
        conf = 1'b0;
        for (int a = 0; a < 32; a++) pre[a] = mem[d][a];
        for (int i = 0; i < nw; i++)
            for (int j = i + 1; j < nw; j++)
                if (s_wr_en[i] && s_wr_en[j] && s_wr_addr[i] == s_wr_addr[j]) conf = 1'b1;
        for (int w = nw - 1; w >= 0; w--)
            if (s_wr_en[w]) mem[d][s_wr_addr[w]] = s_wr_data[w];
        exp_valid[d] = '0;
        for (int r = 0; r < nr; r++) begin
            if (s_rd_en[r]) begin
                exp_valid[d][r] = 1'b1;
                exp_data[d][r]  = rdw ? mem[d][s_rd_addr[r]] : pre[s_rd_addr[r]];
            end
        end
        exp_conf[d] = conf;
    endtask

    // One clock: inputs were set at the preceding negedge, outputs are observed at the next.
    // The sweep takes 32 edges and ready follows one edge later, so ports open from edge 34.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            edges = 0;
            for (int d = 0; d < 2; d++) begin
                exp_valid[d] = '0;
                exp_conf[d]  = 1'b0;
                for (int r = 0; r < 3; r++) exp_data[d][r] = '0;
                for (int a = 0; a < 32; a++) mem[d][a] = '0;
            end
        end else begin
            if (edges >= 33) begin
                model_edge(0, 2, 2, 1'b0);
                model_edge(1, 4, 3, 1'b1);
            end else begin
                for (int d = 0; d < 2; d++) begin
                    exp_valid[d] = '0;
                    exp_conf[d]  = 1'b0;
                end
            end
            edges++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_a, first_b;
        idle();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if ({a_ready, a_rd_valid, a_rd_data, a_conf} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state_a: got %h, expected 0", {a_ready, a_rd_valid, a_rd_data, a_conf});
        end
        n_tests++;
        if ({b_ready, b_rd_valid, b_rd_data, b_conf} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state_b: got %h, expected 0", {b_ready, b_rd_valid, b_rd_data, b_conf});
        end
        reset   = 1'b0;
        first_a = -1;
        first_b = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (a_ready === 1'b1 && first_a < 0) first_a = k;
            if (b_ready === 1'b1 && first_b < 0) first_b = k;
        end
        n_tests++;
        if (first_a != 33) begin
            n_fail++;
            $display("[TB] FAIL ready_latency_a: got %0d cycles, expected 33", first_a);
        end
        n_tests++;
        if (first_b != 33) begin
            n_fail++;
            $display("[TB] FAIL ready_latency_b: got %0d cycles, expected 33", first_b);
        end
    endtask

    task automatic test_init_clear();
        for (int a = 0; a < 32; a++) begin
            idle();
            s_rd_en = 3'b111;
            for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'(a);
            step();
            n_tests++;
            if (a_rd_valid !== 2'b11 || a_rd_data !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL clear_read_a @%0d: got v=%b d=%h, expected v=11 d=0000", a, a_rd_valid, a_rd_data);
            end
            n_tests++;
            if (b_rd_valid !== 3'b111 || b_rd_data !== 24'h0) begin
                n_fail++;
                $display("[TB] FAIL clear_read_b @%0d: got v=%b d=%h, expected v=111 d=000000", a, b_rd_valid, b_rd_data);
            end
        end
    endtask

    task automatic test_overwrite();
        idle();
        s_wr_en = 4'b0001; s_wr_addr[0] = 5'd3; s_wr_data[0] = 8'hAA;
        step();
        idle();
        s_wr_en = 4'b0010; s_wr_addr[1] = 5'd3; s_wr_data[1] = 8'h55;
        step();
        idle();
        s_rd_en = 3'b111;
        for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'd3;
        step();
        n_tests++;
        if (a_rd_valid !== 2'b11 || a_rd_data !== 16'h5555) begin
            n_fail++;
            $display("[TB] FAIL overwrite_a: got v=%b d=%h, expected v=11 d=5555", a_rd_valid, a_rd_data);
        end
        n_tests++;
        if (b_rd_valid !== 3'b111 || b_rd_data !== 24'h555555) begin
            n_fail++;
            $display("[TB] FAIL overwrite_b: got v=%b d=%h, expected v=111 d=555555", b_rd_valid, b_rd_data);
        end
        idle();
        step();
        n_tests++;
        if (a_rd_valid !== 2'b00 || a_rd_data !== 16'h5555) begin
            n_fail++;
            $display("[TB] FAIL hold_a: got v=%b d=%h, expected v=00 d=5555", a_rd_valid, a_rd_data);
        end
        n_tests++;
        if (b_rd_valid !== 3'b000 || b_rd_data !== 24'h555555) begin
            n_fail++;
            $display("[TB] FAIL hold_b: got v=%b d=%h, expected v=000 d=555555", b_rd_valid, b_rd_data);
        end
    endtask

    task automatic test_conflict();
        idle();
        s_wr_en = 4'b0011;
        s_wr_addr[0] = 5'd7; s_wr_data[0] = 8'h11;
        s_wr_addr[1] = 5'd7; s_wr_data[1] = 8'h22;
        step();
        n_tests++;
        if (a_conf !== 1'b1 || b_conf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL conflict_pulse: got a=%b b=%b, expected 1 1", a_conf, b_conf);
        end
        idle();
        s_rd_en = 3'b111;
        for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'd7;
        step();
        n_tests++;
        if (a_conf !== 1'b0 || b_conf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL conflict_single: got a=%b b=%b, expected 0 0", a_conf, b_conf);
        end
        n_tests++;
        if (a_rd_data !== 16'h1111 || b_rd_data !== 24'h111111) begin
            n_fail++;
            $display("[TB] FAIL conflict_winner: got a=%h b=%h, expected 1111 111111", a_rd_data, b_rd_data);
        end
    endtask

    task automatic test_rdw();
        idle();
        s_wr_en = 4'b0001; s_wr_addr[0] = 5'd9; s_wr_data[0] = 8'h01;
        step();
        idle();
        s_wr_en = 4'b0010; s_wr_addr[1] = 5'd9; s_wr_data[1] = 8'h02;
        s_rd_en = 3'b111;
        for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'd9;
        step();
        n_tests++;
        if (a_rd_data !== 16'h0101) begin
            n_fail++;
            $display("[TB] FAIL rdw_old_a: got %h, expected 0101", a_rd_data);
        end
        n_tests++;
        if (b_rd_data !== 24'h020202) begin
            n_fail++;
            $display("[TB] FAIL rdw_new_b: got %h, expected 020202", b_rd_data);
        end
        idle();
        s_rd_en = 3'b111;
        for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'd9;
        step();
        n_tests++;
        if (a_rd_data !== 16'h0202 || b_rd_data !== 24'h020202) begin
            n_fail++;
            $display("[TB] FAIL rdw_after: got a=%h b=%h, expected 0202 020202", a_rd_data, b_rd_data);
        end
    endtask

    task automatic test_reset_mid_init();
        int first_a, first_b;
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            random_stim(1'b1, 31);
            step();
        end
        reset = 1'b1;
        random_stim(1'b1, 31);
        step();
        reset   = 1'b0;
        first_a = -1;
        first_b = -1;
        for (int k = 1; k <= 36; k++) begin
            if (first_a < 0 || first_b < 0) random_stim(1'b1, 31);
            else idle();
            step();
            if (a_ready === 1'b1 && first_a < 0) first_a = k;
            if (b_ready === 1'b1 && first_b < 0) first_b = k;
            if (first_a < 0 && first_b < 0) begin
                n_tests++;
                if ({a_rd_valid, a_conf, b_rd_valid, b_conf} !== '0 || a_rd_data !== '0 || b_rd_data !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL init_quiet k=%0d: got av=%b ac=%b bv=%b bc=%b ad=%h bd=%h, expected all 0",
                             k, a_rd_valid, a_conf, b_rd_valid, b_conf, a_rd_data, b_rd_data);
                end
            end
        end
        n_tests++;
        if (first_a != 33 || first_b != 33) begin
            n_fail++;
            $display("[TB] FAIL restart_ready: got a=%0d b=%0d cycles, expected 33 33", first_a, first_b);
        end
        for (int a = 0; a < 32; a++) begin
            idle();
            s_rd_en = 3'b111;
            for (int r = 0; r < 3; r++) s_rd_addr[r] = 5'(a);
            step();
            n_tests++;
            if (a_rd_data !== 16'h0 || b_rd_data !== 24'h0 || a_rd_valid !== 2'b11 || b_rd_valid !== 3'b111) begin
                n_fail++;
                $display("[TB] FAIL restart_clear @%0d: got a=%h b=%h, expected 0000 000000", a, a_rd_data, b_rd_data);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            random_stim(cyc < 6000, (cyc % 3 == 0) ? 31 : 7);
            step();
            n_tests++;
            if (a_rd_valid !== exp_valid[0][1:0] || a_rd_data !== {exp_data[0][1], exp_data[0][0]}) begin
                n_fail++;
                $display("[TB] FAIL random_read_a cyc=%0d: got v=%b d=%h, expected v=%b d=%h", cyc, a_rd_valid,
                         a_rd_data, exp_valid[0][1:0], {exp_data[0][1], exp_data[0][0]});
            end
            n_tests++;
            if (a_conf !== exp_conf[0]) begin
                n_fail++;
                $display("[TB] FAIL random_conflict_a cyc=%0d: got %b, expected %b", cyc, a_conf, exp_conf[0]);
            end
            n_tests++;
            if (b_rd_valid !== exp_valid[1] || b_rd_data !== {exp_data[1][2], exp_data[1][1], exp_data[1][0]}) begin
                n_fail++;
                $display("[TB] FAIL random_read_b cyc=%0d: got v=%b d=%h, expected v=%b d=%h", cyc, b_rd_valid,
                         b_rd_data, exp_valid[1], {exp_data[1][2], exp_data[1][1], exp_data[1][0]});
            end
            n_tests++;
            if (b_conf !== exp_conf[1]) begin
                n_fail++;
                $display("[TB] FAIL random_conflict_b cyc=%0d: got %b, expected %b", cyc, b_conf, exp_conf[1]);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_init_clear();
        test_overwrite();
        test_conflict();
        test_rdw();
        test_reset_mid_init();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/lvt_mp_ram.md
LVT_MP_RAM -- requirements
Module: lvt_mp_ram

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning address width; depth = 2**ADDR_WIDTH.
- REQ-003 SHALL have parameter NUM_WR, default 2, meaning number of write ports (1..8).
- REQ-004 SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..8).
- REQ-005 SHALL have parameter RDW_NEW, default 0, meaning same-cycle read-during-write returns old data (0) or new data (1).
- REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
- REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-008 SHALL have port wr_en  input  NUM_WR  per-port write enable.
- REQ-009 SHALL have port wr_addr  input  NUM_WR*ADDR_WIDTH  write addresses; port w occupies slice [w*ADDR_WIDTH +: ADDR_WIDTH].
- REQ-010 SHALL have port wr_data  input  NUM_WR*DATA_WIDTH  write data, sliced likewise.
- REQ-011 SHALL have port rd_en  input  NUM_RD  per-port read enable.
- REQ-012 SHALL have port rd_addr  input  NUM_RD*ADDR_WIDTH  read addresses, sliced likewise.
- REQ-013 SHALL have port rd_data  output  NUM_RD*DATA_WIDTH  registered read data, sliced likewise.
- REQ-014 SHALL have port rd_valid  output  NUM_RD  high for one cycle when the matching rd_data slice is valid.
- REQ-015 SHALL have port ready  output  1  high when initialisation is done and ports are accepted.
- REQ-016 SHALL have port wr_conflict  output  1  one-cycle pulse flagging a same-address multi-port write.

Function
- REQ-017 SHALL store data in NUM_WR x NUM_RD banks; bank (w,r) is written only by write port w and read only by read port r.
- REQ-018 SHALL keep a live value table (LVT): one entry of max(1,clog2(NUM_WR)) bits per address, holding the index of the last write port to write that address.
- REQ-019 SHALL have two states: INIT (clear sweep) and RUN.
- REQ-020 In INIT, SHALL use an ADDR_WIDTH-bit counter, starting at 0, to write 0 into every bank and LVT entry at the counter address, one address per cycle.
- REQ-021 SHALL move INIT->RUN on the cycle the counter writes address 2**ADDR_WIDTH-1; ready SHALL go high on the following cycle and stay high until reset.
- REQ-022 In INIT, SHALL ignore wr_en and rd_en; rd_valid SHALL stay 0 and wr_conflict SHALL stay 0.
- REQ-023 In RUN, for each w with wr_en[w], SHALL write wr_data[w] to all banks (w,*) at wr_addr[w] and set LVT[wr_addr[w]] = w at the same edge.
- REQ-024 When two or more enabled write ports share an address in one cycle, the lowest-index port SHALL win the LVT entry and be the stored value; wr_conflict SHALL pulse high the next cycle.
- REQ-025 For a read in RUN with rd_en[r] at edge N, rd_data[r] SHALL be the bank (LVT[rd_addr[r]], r) word, registered at edge N; rd_valid[r]=1 after edge N (latency 1).
- REQ-026 rd_valid[r] SHALL be 0 in any cycle following a clock edge where rd_en[r] was 0; rd_data[r] SHALL then hold its last value.
- REQ-027 For a read and a write to the same address at the same edge, RDW_NEW=0 SHALL return the pre-write value and RDW_NEW=1 SHALL return the winning write's wr_data.
- REQ-028 Multiple read ports at the same address in one cycle SHALL all return the same value.
- REQ-029 Writes at different addresses in the same cycle SHALL all take effect, with no stall.

Reset
- REQ-030 When reset is high at an edge: state=INIT, counter=0, ready=0, rd_valid=0, rd_data=0, wr_conflict=0.
- REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart the sweep from address 0; pending reads are dropped.

Verification
- REQ-032 Reset then idle (ADDR_WIDTH=5) -> ready rises 33 cycles after reset deassertion; read of each address returns 0.
- REQ-033 Port0 writes 0xAA @3, next cycle port1 writes 0x55 @3, then port0 and port1 read @3 -> both return 0x55, rd_valid high 1 cycle after rd_en.
- REQ-034 Port0 writes 0x11 @7 and port1 writes 0x22 @7 in the same cycle -> wr_conflict pulses once; a later read @7 returns 0x11.
- REQ-035 Address 9 holds 0x01; in one cycle write 0x02 @9 on port1 and read @9 -> returns 0x01 with RDW_NEW=0, 0x02 with RDW_NEW=1.
- REQ-036 Reset pulsed at sweep counter=10, with writes and reads driven during INIT -> no rd_valid and no wr_conflict; ready arrives 33 cycles after reset deassertion; memory reads back all 0.
- REQ-037 NUM_WR=4, NUM_RD=3: random traffic with all ports active every cycle, checked against a reference model -> zero mismatches over 10k cycles.
